// File: rtl/uart_rx.sv
// Oversampled UART receiver with optional parity and one-cycle status pulses.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_rx #(
    parameter int DATAWIDTH  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 DATA_VALID,
    output logic                 PAR_ERR,
    output logic                 STP_ERR,
    output logic                 Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    localparam logic [CW-1:0] SAMP_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATAWIDTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] SAMP_V0   = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] SAMP_V1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMP_DEC  = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] SAMP_DEC  = CW'(OVERSAMPLE / 2 - 1);
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_samp_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATAWIDTH-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_typ;
    logic                 r_par_flag;
    logic [DATAWIDTH-1:0] r_pdata;
    logic                 r_dv;
    logic                 r_pe;
    logic                 r_se;

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_at_dec;
    logic                 w_at_last;
    logic                 w_bit;
    logic [DATAWIDTH-1:0] w_shift_next;

    assign w_rx_s       = r_sync2;
    assign w_fall       = r_rx_prev & ~w_rx_s;
    assign w_at_dec     = (r_samp_cnt == SAMP_DEC);
    assign w_at_last    = (r_samp_cnt == SAMP_LAST);
    assign w_shift_next = DATAWIDTH'({w_bit, r_shift} >> 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;

    // The third vote is the live sample at the decision count.
    assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & w_rx_s) | (r_vote1 & w_rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else if (r_state != ST_IDLE) begin
            if (r_samp_cnt == SAMP_V0) r_vote0 <= w_rx_s;
            if (r_samp_cnt == SAMP_V1) r_vote1 <= w_rx_s;
        end
    end
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_state    <= ST_IDLE;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_flag <= 1'b0;
            r_pdata    <= '0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_sync1   <= RX_IN;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_dv      <= 1'b0;
            r_pe      <= 1'b0;
            r_se      <= 1'b0;

            if (r_state == ST_IDLE) begin
                if (w_fall) begin
                    r_state    <= ST_START;
                    r_samp_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_par_en   <= PAR_EN;
                    r_par_typ  <= PAR_TYP;
                    r_par_flag <= 1'b0;
                end
            end else begin
                r_samp_cnt <= w_at_last ? '0 : r_samp_cnt + 1'b1;
                case (r_state)
                    ST_START: begin
                        if (w_at_dec && w_bit) begin
                            r_state <= ST_IDLE;
                        end else if (w_at_last) begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_at_dec) r_shift <= w_shift_next;
                        if (w_at_last) begin
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= r_par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_at_dec && (w_bit != ((^r_shift) ^ r_par_typ))) r_par_flag <= 1'b1;
                        if (w_at_last) r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Leave at mid-stop so a following start edge is never missed.
                        if (w_at_dec) begin
                            r_state <= ST_IDLE;
                            r_se    <= ~w_bit;
                            r_pe    <= r_par_flag;
                            if (w_bit && !r_par_flag) begin
                                r_pdata <= r_shift;
                                r_dv    <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign P_DATA     = r_pdata;
    assign DATA_VALID = r_dv;
    assign PAR_ERR    = r_pe;
    assign STP_ERR    = r_se;
    assign Busy       = (r_state != ST_IDLE) | r_dv | r_pe | r_se;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, meaning clk cycles per bit; legal values 8, 16, 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATAWIDTH  last good received word.
REQ-009 SHALL have port DATA_VALID  output  1  one-cycle pulse, P_DATA updated.
REQ-010 SHALL have port PAR_ERR  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port STP_ERR  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port Busy  output  1  high while a frame is being received.

Function
REQ-013 SHALL pass RX_IN through a 2-flop synchronizer (reset value 1); all logic below uses the synchronized signal rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE, move to START on rx_s high-to-low transition, clear bit counter and sample counter, latch PAR_EN/PAR_TYP for the frame.
REQ-016 SHALL run a sample counter 0..OVERSAMPLE-1 per bit, wrapping to 0 and advancing the bit position on the OVERSAMPLE-1 count.
REQ-017 SHALL take the bit value at sample count OVERSAMPLE/2-1 (mid-bit).
REQ-018 SHALL, in START, return to IDLE with no output pulse if the mid-bit sample is 1 (false start); otherwise go to DATA at the bit boundary.
REQ-019 SHALL shift DATAWIDTH data bits LSB first in DATA, then go to PARITY if latched PAR_EN=1, else STOP.
REQ-020 SHALL, in PARITY, compare sampled bit against XOR of data bits XOR latched PAR_TYP; mismatch sets an internal parity-error flag.
REQ-021 SHALL, in STOP, at the mid-bit sample go to IDLE on the next clk without waiting for bit end, allowing back-to-back frames.
REQ-022 SHALL, on the cycle after the stop mid-bit sample: pulse STP_ERR if stop=0; pulse PAR_ERR if parity flag set; otherwise load P_DATA and pulse DATA_VALID.
REQ-023 SHALL never update P_DATA on an errored frame; P_DATA holds until the next good frame.
REQ-024 SHALL assert Busy from START entry through the cycle DATA_VALID/error pulses, low in IDLE.
REQ-025 SHALL ignore PAR_EN/PAR_TYP changes mid-frame.
REQ-026 SHALL ignore falling edges of rx_s outside IDLE.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, counters 0, synchronizer flops 1, P_DATA 0, DATA_VALID/PAR_ERR/STP_ERR/Busy 0.
REQ-028 SHALL abort any frame on reset mid-frame with no pulses; after release, reception resumes only on a new falling edge.

Configuration
REQ-029 SHALL provide macro UART_RX_MAJORITY_VOTE_EN.
REQ-030 SHALL, when UART_RX_MAJORITY_VOTE_EN is defined, decide each bit by 2-of-3 majority of samples at counts OVERSAMPLE/2-2, OVERSAMPLE/2-1, OVERSAMPLE/2; decision and output timing remain referenced to count OVERSAMPLE/2.
REQ-031 SHALL, when undefined, use the single sample of REQ-017 with timing per REQ-021/REQ-022.

Verification (DATAWIDTH=8, OVERSAMPLE=8)
REQ-032 SHALL cover: frame 0xA5, PAR_EN=0, stop=1 -> one DATA_VALID pulse, P_DATA=0xA5, no errors, Busy low after pulse.
REQ-033 SHALL cover: 0x3C, PAR_EN=1, PAR_TYP=0, parity bit 0 -> DATA_VALID, P_DATA=0x3C; same frame with parity bit 1 -> PAR_ERR pulse, P_DATA unchanged.
REQ-034 SHALL cover: 0x81 with stop bit driven 0 -> STP_ERR pulse, no DATA_VALID, P_DATA keeps previous value.
REQ-035 SHALL cover: RX_IN low for 2 clk then high in IDLE -> false start, back to IDLE, no pulses, Busy low within OVERSAMPLE cycles.
REQ-036 SHALL cover: two back-to-back frames 0x55 then 0xAA, no idle gap -> two DATA_VALID pulses with correct P_DATA each.
REQ-037 SHALL cover: rst pulled low during data bit 4 -> all outputs 0 asynchronously, next full frame 0x0F received correctly; with UART_RX_MAJORITY_VOTE_EN, a 1-cycle glitch on mid-bit sample of frame 0xF0 -> still P_DATA=0xF0.
